cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FU_NUM, default 5, meaning the number of functional units competing for the CDB.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous and active-high reset.
REQ-004 SHALL have port fu_valid, input, FU_NUM, per-FU "result presented this cycle".
REQ-005 SHALL have port fu_result, input, RESULT [FU_NUM-1:0], per-FU result, including value and ROB_tag.
REQ-006 SHALL have port squash, input, 1, branch-mispredict flush.
REQ-007 SHALL have port fu_ready, output, FU_NUM, meaning the holding slot can accept a result this cycle.
REQ-008 SHALL have port out_results, output, RESULT [FU_NUM-1:0], holding-slot contents, which feed the CDB in_results.
REQ-009 SHALL have port select_flag, output, 1, meaning a grant is valid this cycle.
REQ-010 SHALL have port select_signal, output, FU_NUM, the one-hot grant, which feeds the CDB select_signal.

Function
REQ-011 SHALL hold one slot per FU: slot_valid[i] plus the registered RESULT.
REQ-012 Accept: SHALL write fu_result[i] and set slot_valid[i] at the edge when fu_valid[i] && fu_ready[i]; the result is visible on out_results[i] the next cycle (1-cycle latency).
REQ-013 SHALL ignore fu_valid[i] while fu_ready[i] is low; the FU holds its result until it is accepted.
REQ-014 fu_ready[i] SHALL equal ~slot_valid[i] | select_signal[i], so a slot can drain and refill in the same cycle.
REQ-015 Arbitration SHALL be combinational from the slots and rr_ptr: grant the first valid slot found searching i = rr_ptr, rr_ptr+1, ... modulo FU_NUM.
REQ-016 select_flag SHALL equal |slot_valid; select_signal SHALL be one-hot when select_flag=1 and all-zero otherwise.
REQ-017 A granted slot SHALL clear at the next edge, unless it is refilled in that same cycle per REQ-012.
REQ-018 On a grant, rr_ptr SHALL advance to (granted index + 1) modulo FU_NUM, wrapping from FU_NUM-1 to 0; with no grant, rr_ptr SHALL hold.
REQ-019 Fairness: a continuously valid slot SHALL be granted within FU_NUM cycles.
REQ-020 A slot's RESULT register SHALL not change while slot_valid=1 and the slot is not granted.
REQ-021 squash=1 SHALL clear all slot_valid bits at the edge and SHALL drop any same-cycle fu_valid accept; squash wins over accept.
REQ-022 squash SHALL leave rr_ptr unchanged; the current-cycle grant still drives select_flag and select_signal combinationally.
REQ-023 out_results[i] for an invalid slot SHALL be don't-care; the CDB consumes only the granted entry.

Reset
REQ-024 reset=1 SHALL asynchronously clear slot_valid to 0, the RESULT registers to '0, and rr_ptr to 0.
REQ-025 After reset, select_flag=0, select_signal=0, fu_ready=all-ones, and out_results=all-zero.
REQ-026 Reset asserted mid-operation SHALL discard all buffered results with no grant in any cycle where reset is high.

Structure
REQ-027 RESULT (with `XLEN value and ROB_tag) and the `XLEN define SHALL come from the shared system-definitions package; no local redefinition.
REQ-028 The round-robin one-hot picker SHALL be a sub-module rr_picker, taking FU_NUM, req, and ptr and producing a one-hot grant and grant_idx; all state lives in cdb_arbiter.
REQ-029 rr_ptr width SHALL be $clog2(FU_NUM).

Verification
REQ-030 Reset: assert reset mid-stream with 3 slots full -> select_flag=0 and fu_ready=5'b11111 immediately; nothing is granted afterwards.
REQ-031 Single FU: fu_valid=5'b00100 with value=32'hDEAD and ROB_tag=7 at cycle 0 -> cycle 1 gives select_signal=5'b00100 and out_results[2].value=32'hDEAD; cycle 2 gives select_flag=0.
REQ-032 Contention with rr_ptr=0: all 5 FUs valid in one cycle -> grants 00001, 00010, 00100, 01000, 10000 in consecutive cycles, then rr_ptr=0 (wrap).
REQ-033 Back-pressure: FU3 holds valid while its slot is full and ungranted -> fu_ready[3]=0 and the slot value is unchanged; it is accepted on the grant cycle and re-granted later.
REQ-034 Squash: slots 0 and 4 valid and fu_valid[1]=1 with squash=1 -> next cycle slot_valid=0 and select_flag=0, with rr_ptr as advanced by that cycle's grant.
REQ-035 Back-to-back streaming: FU1 presents a result every cycle with no other FU active -> one grant per cycle with fu_ready[1]=1 throughout and no bubble after the first cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions for the CDB arbiter: XLEN and the RESULT record.
`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

  localparam int unsigned ROB_TAG_W = 6;

  typedef struct packed {
    logic [`XLEN-1:0]     value;
    logic [ROB_TAG_W-1:0] ROB_tag;
  } RESULT;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin one-hot picker: first set req bit at or after ptr, wrapping modulo FU_NUM.
module rr_picker #(
  parameter int unsigned FU_NUM = 5,
  localparam int unsigned PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic [FU_NUM-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [FU_NUM-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx
);

  logic found;

  // Two passes: indices at or above ptr first, then the wrapped-around low indices.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(FU_NUM); i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < int'(FU_NUM); i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU holding slots in front of the CDB with a round-robin one-hot grant.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [FU_NUM-1:0]   fu_valid,
  input  RESULT [FU_NUM-1:0]  fu_result,
  input  logic                squash,
  output logic [FU_NUM-1:0]   fu_ready,
  output RESULT [FU_NUM-1:0]  out_results,
  output logic                select_flag,
  output logic [FU_NUM-1:0]   select_signal
);

  localparam int unsigned PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  logic [FU_NUM-1:0]  slot_valid;
  RESULT [FU_NUM-1:0] slot_data;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [FU_NUM-1:0]  accept;

  rr_picker #(
    .FU_NUM (FU_NUM)
  ) u_picker (
    .req       (slot_valid),
    .ptr       (rr_ptr),
    .grant     (select_signal),
    .grant_idx (grant_idx)
  );

  assign select_flag = |slot_valid;
  assign out_results = slot_data;
  // A granted slot drains this cycle, so it may be refilled at the same edge.
  assign fu_ready    = ~slot_valid | select_signal;
  assign accept      = fu_valid & fu_ready;
  assign rr_ptr_next = (grant_idx == PTR_W'(FU_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      slot_data  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (select_flag) begin
        rr_ptr <= rr_ptr_next;
      end
      for (int i = 0; i < int'(FU_NUM); i++) begin
        if (squash) begin
          slot_valid[i] <= 1'b0;
        end else if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= fu_result[i];
        end else if (select_signal[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded random/directed bench for cdb_arbiter against a slot-level reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 5;

  logic              clock;
  logic              reset;
  logic [N-1:0]      fu_valid;
  RESULT [N-1:0]     fu_result;
  logic              squash;
  logic [N-1:0]      fu_ready;
  RESULT [N-1:0]     out_results;
  logic              select_flag;
  logic [N-1:0]      select_signal;

  cdb_arbiter #(
    .FU_NUM (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_valid      (fu_valid),
    .fu_result     (fu_result),
    .squash        (squash),
    .fu_ready      (fu_ready),
    .out_results   (out_results),
    .select_flag   (select_flag),
    .select_signal (select_signal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int    idx;
    RESULT r;
  } exp_t;

  exp_t  exp_q[$];
  int    grant_log[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model: slot contents, round-robin pointer, and the FUs' pending results.
  bit    m_valid [N];
  RESULT m_slot  [N];
  int    m_ptr;
  bit    fu_pend [N];
  RESULT fu_res  [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic RESULT new_result();
    RESULT r;
    r.value   = $urandom;
    r.ROB_tag = ROB_TAG_W'($urandom_range(0, (1 << ROB_TAG_W) - 1));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_slot[i]  = '0;
      fu_pend[i] = 1'b0;
      fu_res[i]  = '0;
    end
    m_ptr = 0;
  endtask

  // One cycle: drive inputs, predict this cycle's grant and readiness, advance the model.
  task automatic step(input bit sq);
    int           g;
    logic [N-1:0] mready;
    bit           acc;
    for (int i = 0; i < N; i++) begin
      fu_valid[i]  = fu_pend[i];
      fu_result[i] = fu_res[i];
    end
    squash = sq;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) mready[i] = !m_valid[i] || (i == g);
    chk("fu_ready", 64'(fu_ready), 64'(mready));
    if (g >= 0) exp_q.push_back('{idx: g, r: m_slot[g]});
    if (g >= 0) m_ptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      acc = fu_pend[i] && mready[i];
      if (sq) begin
        m_valid[i] = 1'b0;
      end else if (acc) begin
        m_valid[i] = 1'b1;
        m_slot[i]  = fu_res[i];
      end else if (i == g) begin
        m_valid[i] = 1'b0;
      end
      if (acc || sq) fu_pend[i] = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) fu_pend[i] = 1'b0;
    repeat (N + 1) step(1'b0);
  endtask

  // Monitor: every presented grant must match the oldest predicted grant.
  always @(negedge clock) begin
    exp_t e;
    int   act_idx;
    if (!reset) begin
      if (select_flag) begin
        act_idx = -1;
        for (int i = 0; i < N; i++) if (select_signal[i] && act_idx < 0) act_idx = i;
        grant_log.push_back(act_idx);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 64'(select_signal), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("select_signal", 64'(select_signal), 64'(1) << e.idx);
          chk("granted_result", 64'(out_results[e.idx]), 64'(e.r));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missed_grant", 64'(select_flag), 64'(1));
      end
    end
  end

  initial begin
    int pct;
    reset    = 1'b1;
    fu_valid = '0;
    squash   = 1'b0;
    for (int i = 0; i < N; i++) fu_result[i] = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_select_flag", 64'(select_flag), 64'(0));
    chk("reset_select_signal", 64'(select_signal), 64'(0));
    chk("reset_fu_ready", 64'(fu_ready), 64'h1f);
    for (int i = 0; i < N; i++) chk("reset_out_results", 64'(out_results[i]), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single FU with a known result.
    fu_pend[2] = 1'b1;
    fu_res[2]  = '{value: 32'hDEAD, ROB_tag: ROB_TAG_W'(7)};
    step(1'b0);
    chk("single_select", 64'(select_signal), 64'b00100);
    chk("single_value", 64'(out_results[2].value), 64'hDEAD);
    chk("single_tag", 64'(out_results[2].ROB_tag), 64'd7);
    step(1'b0);
    chk("single_idle", 64'(select_flag), 64'(0));
    step(1'b0);

    // Reset with three slots full.
    fu_pend[0] = 1'b1; fu_res[0] = new_result();
    fu_pend[1] = 1'b1; fu_res[1] = new_result();
    fu_pend[3] = 1'b1; fu_res[3] = new_result();
    step(1'b0);
    fu_valid = '0;
    reset    = 1'b1;
    #1;
    chk("midreset_select_flag", 64'(select_flag), 64'(0));
    chk("midreset_fu_ready", 64'(fu_ready), 64'h1f);
    exp_q.delete();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) step(1'b0);

    // Full contention from pointer 0, then check the wrap.
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      fu_pend[i] = 1'b1;
      fu_res[i]  = new_result();
    end
    step(1'b0);
    repeat (N) step(1'b0);
    chk("contention_count", 64'(grant_log.size()), 64'(N));
    for (int i = 0; i < N && i < grant_log.size(); i++) chk("contention_order", 64'(grant_log[i]), 64'(i));
    fu_pend[0] = 1'b1; fu_res[0] = new_result();
    fu_pend[4] = 1'b1; fu_res[4] = new_result();
    step(1'b0);
    chk("wrap_grant", 64'(select_signal), 64'b00001);
    drain();

    // Back-pressure on FU3 behind a full set of slots.
    for (int i = 0; i < N; i++) begin
      fu_pend[i] = 1'b1;
      fu_res[i]  = new_result();
    end
    step(1'b0);
    for (int c = 0; c < 2 * N; c++) begin
      if (!fu_pend[3] && c < N) begin
        fu_pend[3] = 1'b1;
        fu_res[3]  = new_result();
      end
      step(1'b0);
    end
    drain();

    // Back-to-back streaming from FU1.
    for (int c = 0; c < 8; c++) begin
      fu_pend[1] = 1'b1;
      fu_res[1]  = new_result();
      step(1'b0);
      chk("stream_ready", 64'(fu_ready[1]), 64'(1));
      if (c > 0) chk("stream_grant", 64'(select_signal), 64'b00010);
    end
    drain();

    // Squash with slots 0 and 4 full and FU1 presenting.
    fu_pend[0] = 1'b1; fu_res[0] = new_result();
    fu_pend[4] = 1'b1; fu_res[4] = new_result();
    step(1'b0);
    fu_pend[1] = 1'b1; fu_res[1] = new_result();
    step(1'b1);
    chk("squash_select_flag", 64'(select_flag), 64'(0));
    chk("squash_fu_ready", 64'(fu_ready), 64'h1f);
    step(1'b0);

    // Random traffic with occasional squashes.
    for (int c = 0; c < 400; c++) begin
      pct = (c < 200) ? 35 : 80;
      for (int i = 0; i < N; i++) begin
        if (!fu_pend[i] && $urandom_range(0, 99) < pct) begin
          fu_pend[i] = 1'b1;
          fu_res[i]  = new_result();
        end
      end
      step($urandom_range(0, 15) == 0);
    end
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
